// File: rtl/mic_frame_sequencer_pkg.sv
// Shared types and defaults for the microphone frame sequencer.
package mic_pkg;

    localparam int NUM_MICS_DEFAULT = 4;
    localparam int SAMPLE_W_DEFAULT = 24;
    localparam int OUT_W_DEFAULT    = 16;
    localparam int CNT_W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        COLLECT = 2'd2
    } seq_state_t;

    // One frame at the default geometry; channel k sits in element k.
    typedef logic [NUM_MICS_DEFAULT-1:0][OUT_W_DEFAULT-1:0] mic_frame_t;

endpackage

// File: rtl/mic_frame_sequencer_if.sv
// Sample-stream input and frame-output handshake bundle.
// The slave view belongs to the sequencer; the master view to its neighbours.
interface mic_frame_sequencer_if
    import mic_pkg::*;
#(
    parameter int NUM_MICS = NUM_MICS_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int OUT_W    = OUT_W_DEFAULT
);
    localparam int CH_W = $clog2(NUM_MICS);

    logic [SAMPLE_W-1:0]       s_axis_tdata;
    logic [CH_W-1:0]           s_axis_tid;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic [NUM_MICS*OUT_W-1:0] m_frame_data;
    logic                      m_frame_valid;
    logic                      m_frame_ready;

    modport master (
        output s_axis_tdata, s_axis_tid, s_axis_tvalid, m_frame_ready,
        input  s_axis_tready, m_frame_data, m_frame_valid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tid, s_axis_tvalid, m_frame_ready,
        output s_axis_tready, m_frame_data, m_frame_valid
    );

endinterface

// File: rtl/mic_frame_sequencer_sat_counter.sv
// Event counter that either saturates at all-ones or wraps.
module sat_counter #(
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count one per inc; hold at the top when saturating.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (inc && !(SATURATE && (count == CNT_MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mic_frame_sequencer.sv
// Gathers one sample per microphone, in channel order, into a frame and
// hands completed frames downstream under valid/ready. Out-of-order
// channels resynchronise the collector; frames that find the output
// register busy are dropped and counted.
//
//   state   | meaning
//   IDLE    | capture disabled, beats discarded
//   SYNC    | waiting for a channel 0 beat to start a frame
//   COLLECT | frame in progress, exp_ch is the next channel wanted
module mic_frame_sequencer
    import mic_pkg::*;
#(
    parameter int NUM_MICS = NUM_MICS_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int OUT_W    = OUT_W_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    mic_frame_sequencer_if.slave  bus,
    output logic                  sync_err,
    output logic [CNT_W-1:0]      drop_count,
    output logic [CNT_W-1:0]      frame_count
);
    localparam int              CH_W    = $clog2(NUM_MICS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_MICS - 1);

    seq_state_t                     state, state_n;
    logic [CH_W-1:0]                exp_ch, exp_ch_n;
    logic [NUM_MICS-1:0][OUT_W-1:0] frame_buf;
    logic [NUM_MICS-1:0][OUT_W-1:0] frame_n;
    logic [NUM_MICS-1:0][OUT_W-1:0] out_reg;
    logic                           out_valid;
    logic                           tready_q;
    logic                           beat;
    logic                           buf_we;
    logic                           err_n;
    logic                           complete;
    logic                           handshake;
    logic                           load;
    logic                           drop;
    logic [OUT_W-1:0]               sample_cvt;

    assign beat       = bus.s_axis_tvalid & tready_q;
    assign sample_cvt = bus.s_axis_tdata[SAMPLE_W-1 -: OUT_W];

    // The truncated LSBs are deliberately ignored.
    generate
        if (SAMPLE_W > OUT_W) begin : g_lsbs
            logic unused_lsbs;
            assign unused_lsbs = ^bus.s_axis_tdata[SAMPLE_W-OUT_W-1:0];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            exp_ch <= '0;
        end else begin
            state  <= state_n;
            exp_ch <= exp_ch_n;
        end
    end

    // Next-state decode: channel-order tracking and frame completion.
    always_comb begin
        state_n  = state;
        exp_ch_n = exp_ch;
        buf_we   = 1'b0;
        err_n    = 1'b0;
        complete = 1'b0;
        if (!enable_in) begin
            state_n  = IDLE;
            exp_ch_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SYNC;
                end
                SYNC: begin
                    if (beat && (bus.s_axis_tid == '0)) begin
                        buf_we   = 1'b1;
                        exp_ch_n = CH_W'(1);
                        state_n  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (beat) begin
                        if (bus.s_axis_tid == exp_ch) begin
                            buf_we = 1'b1;
                            if (bus.s_axis_tid == LAST_CH) begin
                                complete = 1'b1;
                                exp_ch_n = '0;
                                state_n  = SYNC;
                            end else begin
                                exp_ch_n = exp_ch + CH_W'(1);
                            end
                        end else begin
                            err_n = 1'b1;
                            if (bus.s_axis_tid == '0) begin
                                buf_we   = 1'b1;
                                exp_ch_n = CH_W'(1);
                            end else begin
                                exp_ch_n = '0;
                                state_n  = SYNC;
                            end
                        end
                    end
                end
                default: begin
                    state_n  = IDLE;
                    exp_ch_n = '0;
                end
            endcase
        end
    end

    // Frame as it will look once the current beat is written in.
    always_comb begin
        frame_n                 = frame_buf;
        frame_n[bus.s_axis_tid] = sample_cvt;
    end

    assign handshake = out_valid & bus.m_frame_ready;
    assign load      = complete & (~out_valid | bus.m_frame_ready);
    assign drop      = complete & out_valid & ~bus.m_frame_ready;

    // Frame buffer, output register and the error pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tready_q  <= 1'b0;
            frame_buf <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            sync_err <= err_n;
            if (buf_we) begin
                frame_buf <= frame_n;
            end
            if (load) begin
                out_reg   <= frame_n;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready = tready_q;
    assign bus.m_frame_data  = out_reg;
    assign bus.m_frame_valid = out_valid;

    sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_drop_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .inc    (drop),
        .count  (drop_count)
    );

    sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .inc    (handshake),
        .count  (frame_count)
    );

endmodule

// File: tb/tb_mic_frame_sequencer.sv
// Bench for mic_frame_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_mic_frame_sequencer;
    import mic_pkg::*;

    localparam int N  = 4;
    localparam int SW = 24;
    localparam int OW = 16;
    localparam int CW = 16;

    logic          clk_100mhz = 1'b0;
    logic          rst_in;
    logic          enable_in;
    logic          sync_err;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] frame_count;

    int checks   = 0;
    int failures = 0;

    mic_frame_sequencer_if #(.NUM_MICS(N), .SAMPLE_W(SW), .OUT_W(OW)) bus ();

    mic_frame_sequencer #(.NUM_MICS(N), .SAMPLE_W(SW), .OUT_W(OW), .CNT_W(CW)) dut (
        .clk_in      (clk_100mhz),
        .rst_in      (rst_in),
        .enable_in   (enable_in),
        .bus         (bus),
        .sync_err    (sync_err),
        .drop_count  (drop_count),
        .frame_count (frame_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Reference model: a frame in progress is just the list of samples
    // received so far; its length is the next channel expected.
    bit          m_armed;
    bit          m_tready;
    bit          m_valid;
    bit          m_err;
    mic_frame_t  m_data;
    int          m_drop;
    int          m_fc;
    logic [15:0] q[$];

    typedef struct {
        logic        rst;
        logic        en;
        logic        vld;
        logic [1:0]  tid;
        logic [23:0] data;
        logic        rdy;
        logic        ev;
        logic [63:0] ed;
        logic        ee;
        logic [15:0] edrop;
        logic [15:0] efc;
        logic        etr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [1:0] id,
                                input logic [23:0] d, input logic rd, input logic ev, input logic [63:0] ed,
                                input logic ee, input logic [15:0] edrop, input logic [15:0] efc,
                                input logic etr);
        vec_t t;
        t.rst = r; t.en = e; t.vld = v; t.tid = id; t.data = d; t.rdy = rd;
        t.ev = ev; t.ed = ed; t.ee = ee; t.edrop = edrop; t.efc = efc; t.etr = etr;
        return t;
    endfunction

    function automatic mic_frame_t frame_of(input logic [15:0] base);
        mic_frame_t f;
        for (int k = 0; k < N; k++) f[k] = base + 16'(k);
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic v, input logic [1:0] id,
                              input logic [23:0] d, input logic rd);
        bit         hs;
        bit         done;
        mic_frame_t nf;
        nf   = '0;
        done = 1'b0;
        if (r) begin
            m_armed = 0; m_tready = 0; m_valid = 0; m_err = 0;
            m_data = '0; m_drop = 0; m_fc = 0;
            q.delete();
        end else begin
            hs    = m_valid && rd;
            m_err = 0;
            if (!e) begin
                q.delete();
            end else if (m_armed && m_tready && v) begin
                if (q.size() == 0) begin
                    if (id == 0) q.push_back(d[23:8]);
                end else if (int'(id) == q.size()) begin
                    q.push_back(d[23:8]);
                    if (q.size() == N) begin
                        for (int k = 0; k < N; k++) nf[k] = q[k];
                        done = 1'b1;
                        q.delete();
                    end
                end else begin
                    m_err = 1;
                    q.delete();
                    if (id == 0) q.push_back(d[23:8]);
                end
            end
            if (hs) m_fc = (m_fc + 1) % 65536;
            if (done && (!m_valid || rd)) begin
                m_data  = nf;
                m_valid = 1;
            end else begin
                if (done && m_drop < 65535) m_drop++;
                if (hs) m_valid = 0;
            end
            m_armed  = e;
            m_tready = 1;
        end
    endtask

    task automatic compare_model();
        check("m_tready", 64'(bus.s_axis_tready), 64'(m_tready));
        check("m_valid", 64'(bus.m_frame_valid), 64'(m_valid));
        check("m_sync_err", 64'(sync_err), 64'(m_err));
        check("m_drop_count", 64'(drop_count), 64'(m_drop));
        check("m_frame_count", 64'(frame_count), 64'(m_fc));
        if (m_valid) check("m_frame_data", bus.m_frame_data, m_data);
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [1:0] id,
                        input logic [23:0] d, input logic rd);
        rst_in            = r;
        enable_in         = e;
        bus.s_axis_tvalid = v;
        bus.s_axis_tid    = id;
        bus.s_axis_tdata  = d;
        bus.m_frame_ready = rd;
        @(posedge clk_100mhz);
        model_step(r, e, v, id, d, rd);
        #1;
        compare_model();
    endtask

    task automatic beat(input logic [1:0] id, input logic [23:0] d, input logic rd);
        step(1'b0, 1'b1, 1'b1, id, d, rd);
    endtask

    task automatic idle(input logic rd);
        step(1'b0, 1'b1, 1'b0, 2'd0, 24'd0, rd);
    endtask

    task automatic send_frame(input logic [15:0] base, input logic rd);
        logic [15:0] s;
        for (int k = 0; k < N; k++) begin
            s = base + 16'(k);
            beat(2'(k), {s, 8'h5A}, rd);
        end
    endtask

    initial begin
        logic [1:0]  nxt_tid;
        logic [1:0]  id;
        int          rdy_pct;
        rst_in            = 1'b1;
        enable_in         = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tid    = '0;
        bus.s_axis_tdata  = '0;
        bus.m_frame_ready = 1'b0;
        m_armed = 0; m_tready = 0; m_valid = 0; m_err = 0;
        m_data = '0; m_drop = 0; m_fc = 0;

        //           rst en vld tid data         rdy | valid data                   err drop fc tready
        vecs.push_back(mk(1, 0, 0, 0, 24'h000000, 0, 0, 64'h0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 24'h000000, 0, 0, 64'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 24'h000000, 0, 0, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 24'h123456, 0, 0, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 24'hFEDCBA, 0, 0, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 24'h7FFFFF, 0, 0, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 3, 24'h800000, 0, 1, 64'h8000_7FFF_FEDC_1234, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 24'h000000, 0, 1, 64'h8000_7FFF_FEDC_1234, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 24'h000000, 1, 0, 64'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 2, 24'h999999, 1, 0, 64'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 3, 24'h888888, 1, 0, 64'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 24'h111111, 1, 0, 64'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 24'h222222, 1, 0, 64'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 2, 24'h333333, 1, 0, 64'h0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 3, 24'h444444, 1, 1, 64'h4444_3333_2222_1111, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 24'h000000, 1, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 0, 24'hAAAAAA, 1, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 1, 24'hBBBBBB, 1, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 3, 24'hCCCCCC, 1, 0, 64'h0, 1, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 24'h000000, 1, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 0, 24'h010000, 0, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 1, 24'h020000, 0, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 2, 24'h030000, 0, 0, 64'h0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 1, 3, 24'h040000, 0, 1, 64'h0400_0300_0200_0100, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 24'h000000, 1, 0, 64'h0, 0, 0, 3, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].tid, vecs[i].data, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), 64'(bus.m_frame_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_sync_err", i), 64'(sync_err), 64'(vecs[i].ee));
            check($sformatf("vec%0d_drop", i), 64'(drop_count), 64'(vecs[i].edrop));
            check($sformatf("vec%0d_fcount", i), 64'(frame_count), 64'(vecs[i].efc));
            check($sformatf("vec%0d_tready", i), 64'(bus.s_axis_tready), 64'(vecs[i].etr));
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), bus.m_frame_data, vecs[i].ed);
        end

        // Backpressure: three frames while blocked, first one held.
        send_frame(16'h1000, 1'b0);
        send_frame(16'h2000, 1'b0);
        send_frame(16'h3000, 1'b0);
        check("bp_drop", 64'(drop_count), 64'd2);
        check("bp_held_data", bus.m_frame_data, frame_of(16'h1000));
        check("bp_valid", 64'(bus.m_frame_valid), 64'd1);
        idle(1'b1);
        check("bp_fcount", 64'(frame_count), 64'd4);
        check("bp_valid_drop", 64'(bus.m_frame_valid), 64'd0);

        // Handshake in the very cycle a new frame completes.
        send_frame(16'h4000, 1'b0);
        beat(2'd0, 24'h500000, 1'b0);
        beat(2'd1, 24'h500100, 1'b0);
        beat(2'd2, 24'h500200, 1'b0);
        beat(2'd3, 24'h500300, 1'b1);
        check("same_cycle_valid", 64'(bus.m_frame_valid), 64'd1);
        check("same_cycle_data", bus.m_frame_data, frame_of(16'h5000));
        check("same_cycle_drop", 64'(drop_count), 64'd2);
        check("same_cycle_fcount", 64'(frame_count), 64'd5);
        idle(1'b1);

        // Enable dropped mid-frame, then a beat while still idle.
        beat(2'd0, 24'h600000, 1'b1);
        beat(2'd1, 24'h600100, 1'b1);
        step(1'b0, 1'b0, 1'b1, 2'd2, 24'h600200, 1'b1);
        step(1'b0, 1'b1, 1'b1, 2'd0, 24'hDEAD00, 1'b1);
        send_frame(16'h7000, 1'b1);
        check("reenable_data", bus.m_frame_data, frame_of(16'h7000));
        check("reenable_valid", 64'(bus.m_frame_valid), 64'd1);

        // Reset while a frame is pending.
        step(1'b1, 1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
        check("rst_valid", 64'(bus.m_frame_valid), 64'd0);
        check("rst_fcount", 64'(frame_count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_tready", 64'(bus.s_axis_tready), 64'd0);

        // Randomized traffic against the model.
        nxt_tid = '0;
        rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 256 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 10;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 95;
                endcase
            end
            if ($urandom_range(0, 9) == 0) id = 2'($urandom_range(0, 3));
            else id = nxt_tid;
            step(1'($urandom_range(0, 999) == 0),
                 1'($urandom_range(0, 99) < 97),
                 1'($urandom_range(0, 3) != 0),
                 id,
                 24'($urandom),
                 1'($urandom_range(0, 99) < rdy_pct));
            if (bus.s_axis_tvalid) nxt_tid = id + 2'd1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
